uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single SoC UART transmitter among several on-chip byte producers, such as the CPU console path, a hardware trace logger and the boot monitor.
- Sits between the producers and the UART write port.
- Issues one byte write at a time and waits on the UART `tx_ready` status before it issues the next.
- Optional message locking keeps multi-byte messages from interleaving on the serial line.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GRANT_W`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `hb_clk`  in  1: bus clock. Everything is clocked on its rising edge.
- `hb_rst`  in  1: asynchronous, active-high reset.
- `req`  in  NUM_REQ: per-requester "byte available". Held high until that requester's `ack`.
- `req_last`  in  NUM_REQ: marks the presented byte as the final byte of a message. Only used with locking.
- `req_data`  in  8*NUM_REQ: byte of requester i on bits [8i+7:8i]. Held stable while `req[i]` is high.
- `ack`  out  NUM_REQ: one-cycle pulse, byte accepted.
- `uart_wen`  out  1: one-cycle write strobe to the UART TX data register.
- `uart_wdata`  out  8: byte for the UART. Valid while `uart_wen` is high.
- `uart_tx_ready`  in  1: UART status bit. High = transmitter idle.
- `busy`  out  1: high from byte issue until `uart_tx_ready` returns.
- `grant_id`  out  GRANT_W: index of the last or current granted requester.

## Operation
States:
- `ARB`
- `ISSUE`
- `GUARD`
- `WAIT`

`ARB`:
- Eligible set = `req`, masked to the lock owner only while a lock is held.
- If the eligible set is non-empty and `uart_tx_ready`=1:
  - pick the winner round-robin, starting at `rr_ptr`;
  - register `grant_id`;
  - go to `ISSUE`.

`ISSUE`:
- `uart_wen`=1.
- `uart_wdata` = winner's byte.
- `ack[grant_id]`=1.
- `busy`=1.
- `rr_ptr` ← `grant_id`+1, wrapping modulo NUM_REQ.
- Next state `GUARD`.

`GUARD`:
- Exactly one cycle; `uart_tx_ready` is ignored.
- This covers the cycle the UART needs before it reports not-ready.
- Next state `WAIT`.

`WAIT`:
- When `uart_tx_ready`=1: `busy`=0, go to `ARB`.

Round robin:
- The requester after the last winner has highest priority.
- Search wraps from NUM_REQ-1 to 0.
- `rr_ptr` resets to 0, so requester 0 wins the first contest.

Boundaries:
- All `req` low: stay in `ARB`, outputs idle.
- `uart_tx_ready` low in `ARB` (UART still busy from another writer): no issue.
- A `req` deasserted before `ack` is a protocol error. The arbiter re-samples every cycle in `ARB`, so the withdrawn request is simply not granted.
- Reset mid-operation:
  - state → `ARB`, `rr_ptr`=0, lock cleared, all outputs 0;
  - a byte already handed to the UART still completes on the line.

## Timing
- Reset values: `uart_wen`=0, `uart_wdata`=0, `ack`=0, `busy`=0, `grant_id`=0.
- All outputs are registered.
- Latency from `req` rising (with `uart_tx_ready`=1, state `ARB`) to `uart_wen`/`ack`: 2 edges (`ARB` decide, then `ISSUE` drive).
- `ack` and `uart_wen` are asserted in the same cycle. The requester may present its next byte from the following cycle.
- Minimum spacing between `uart_wen` pulses: 4 cycles, plus the UART busy time.
- `busy` rises with `uart_wen` and falls on the edge after `uart_tx_ready` is seen high.

## Configuration
Macro `UART_TX_ARB_LOCK_EN`.

Defined:
- On a grant with `req_last`=0, the winner becomes lock owner.
- Only the owner is eligible until a byte with `req_last`=1 is acked; the lock clears in that byte's `ISSUE` cycle.
- While the owner has `req` low, the arbiter idles in `ARB` and other requesters wait.

Undefined:
- `req_last` is ignored.
- Every byte is arbitrated independently.

## Structure
- Shared package `uart_pkg`:
  - `uart_arb_state_t` enum (`ARB`/`ISSUE`/`GUARD`/`WAIT`, 2 bits);
  - `UART_ARB_MAX_REQ` = 8.
- Sub-module `rr_picker`:
  - parameter NUM_REQ;
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any-valid.
- Everything else (FSM, lock, output registers) lives in `uart_tx_arbiter`.

## Test plan
- Single requester: `req[2]`=1, `req_data[2]`=0x41, `uart_tx_ready`=1 → exactly one `uart_wen` with `uart_wdata`=0x41 two edges later, `ack[2]` in the same cycle, `busy` until `uart_tx_ready` returns.
- Fairness: all four `req` held high with `uart_tx_ready` modelled (low 10 cycles after each write) → grant order 0,1,2,3,0, with no requester granted twice in a row.
- Backpressure: `uart_tx_ready`=0 for 50 cycles with `req[1]`=1 → no `uart_wen`. Issue occurs 2 edges after `uart_tx_ready` rises.
- Guard: UART model drops `uart_tx_ready` one cycle after `uart_wen` → no second write while the first is in flight.
- Lock (`UART_TX_ARB_LOCK_EN`):
  - requester 0 sends 0x10,0x11,0x12, with `req_last` on 0x12, while requester 1 has 0x20 pending → UART sees 0x10,0x11,0x12,0x20;
  - without the macro → 0x10,0x20,0x11,0x12.
- Reset: assert `hb_rst` during `WAIT` → all outputs 0 asynchronously. After release, requester 0 has priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and requester limit.
package uart_pkg;

    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } uart_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: lowest-numbered request at or after ptr wins, wrapping at NUM_REQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GRANT_W-1:0] gnt_idx,
    output logic               any_vld
);

    localparam int IW = GRANT_W + 1;

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      raw_idx;
    logic [IW-1:0]      wrap_idx;

    // Rotate so bit 0 is the requester at ptr; bit j is then requester ptr+j.
    assign rot     = NUM_REQ'({req, req} >> ptr);
    assign any_vld = |req;

    always_comb begin
        raw_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                raw_idx = {1'b0, ptr} + IW'(j);
            end
        end
        wrap_idx = (raw_idx >= IW'(NUM_REQ)) ? (raw_idx - IW'(NUM_REQ)) : raw_idx;
    end

    assign gnt_idx = wrap_idx[GRANT_W-1:0];
    assign gnt     = any_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX port among NUM_REQ byte producers; UART_TX_ARB_LOCK_EN keeps messages whole.
// Latency: req to uart_wen/ack is 2 edges; issues are at least 4 cycles apart plus UART busy time.
// Backpressure: no issue while uart_tx_ready is low; requesters hold req/req_data until their ack pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic                   hb_clk,
    input  logic                   hb_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   uart_wen,
    output logic [7:0]             uart_wdata,
    input  logic                   uart_tx_ready,
    output logic                   busy,
    output logic [GRANT_W-1:0]     grant_id
);

    uart_arb_state_t    state_q, state_d;
    logic [GRANT_W-1:0] rr_ptr, rr_d, grant_d;
    logic [NUM_REQ-1:0] grant_oh, grant_oh_d;
    logic [NUM_REQ-1:0] eligible, pick_gnt, ack_d;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_vld;
    logic               wen_d, busy_d;
    logic [7:0]         wdata_d;
    logic [GRANT_W:0]   rr_sum;
    logic [GRANT_W-1:0] rr_inc;

`ifdef UART_TX_ARB_LOCK_EN
    logic               lock_vld, lock_vld_d;
    logic [NUM_REQ-1:0] lock_mask, lock_mask_d;

    assign eligible = lock_vld ? (req & lock_mask) : req;
`else
    logic unused_req_last;

    assign unused_req_last = ^req_last;
    assign eligible        = req;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any_vld (pick_vld)
    );

    assign rr_sum = {1'b0, grant_id} + (GRANT_W+1)'(1);
    assign rr_inc = (rr_sum >= (GRANT_W+1)'(NUM_REQ)) ? '0 : rr_sum[GRANT_W-1:0];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_ptr;
        grant_d    = grant_id;
        grant_oh_d = grant_oh;
        wen_d      = 1'b0;
        ack_d      = '0;
        wdata_d    = uart_wdata;
        busy_d     = busy;
`ifdef UART_TX_ARB_LOCK_EN
        lock_vld_d  = lock_vld;
        lock_mask_d = lock_mask;
`endif
        case (state_q)
            ARB: begin
                if (pick_vld && uart_tx_ready) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_gnt;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wen_d   = 1'b1;
                wdata_d = 8'(req_data >> {grant_id, 3'b000});
                ack_d   = grant_oh;
                busy_d  = 1'b1;
                rr_d    = rr_inc;
`ifdef UART_TX_ARB_LOCK_EN
                // A non-final byte claims the line; the final byte releases it.
                lock_vld_d  = !req_last[grant_id];
                lock_mask_d = grant_oh;
`endif
                state_d = GUARD;
            end
            // UART status lags the write strobe by a cycle, so ready is not trusted here.
            GUARD: state_d = WAIT;
            WAIT: begin
                if (uart_tx_ready) begin
                    busy_d  = 1'b0;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge hb_clk or posedge hb_rst) begin
        if (hb_rst) begin
            state_q    <= ARB;
            rr_ptr     <= '0;
            grant_id   <= '0;
            grant_oh   <= '0;
            uart_wen   <= 1'b0;
            uart_wdata <= '0;
            ack        <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr     <= rr_d;
            grant_id   <= grant_d;
            grant_oh   <= grant_oh_d;
            uart_wen   <= wen_d;
            uart_wdata <= wdata_d;
            ack        <= ack_d;
            busy       <= busy_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_ff @(posedge hb_clk or posedge hb_rst) begin
        if (hb_rst) begin
            lock_vld  <= 1'b0;
            lock_mask <= '0;
        end else begin
            lock_vld  <= lock_vld_d;
            lock_mask <= lock_mask_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a queued requester model and a simple UART busy model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic            hb_clk = 1'b0;
    logic            hb_rst;
    logic [NR-1:0]   req;
    logic [NR-1:0]   req_last;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   ack;
    logic            uart_wen;
    logic [7:0]      uart_wdata;
    logic            uart_tx_ready;
    logic            busy;
    logic [1:0]      grant_id;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] rbytes[NR][8];
    bit         rlast[NR][8];
    int         rcnt[NR];
    int         rpos[NR];

    logic [7:0] log_data[$];
    logic [1:0] log_gid[$];
    int         log_cyc[$];

    bit uart_auto;
    int drop_delay;
    int busy_len;
    int busy_cnt;
    bit pend;

    always #5 hb_clk = ~hb_clk;

    uart_tx_arbiter #(.NUM_REQ(NR)) dut (
        .hb_clk        (hb_clk),
        .hb_rst        (hb_rst),
        .req           (req),
        .req_last      (req_last),
        .req_data      (req_data),
        .ack           (ack),
        .uart_wen      (uart_wen),
        .uart_wdata    (uart_wdata),
        .uart_tx_ready (uart_tx_ready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    task automatic present_all();
        for (int i = 0; i < NR; i++) begin
            if (rpos[i] < rcnt[i]) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = rbytes[i][rpos[i]];
                req_last[i]       = rlast[i][rpos[i]];
            end else begin
                req[i]      = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic [7:0] b, input bit l);
        rbytes[i][rcnt[i]] = b;
        rlast[i][rcnt[i]]  = l;
        rcnt[i]++;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NR; i++) if (rpos[i] < rcnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_log();
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    // One clock; everything observed and driven at the falling edge.
    task automatic step();
        @(posedge hb_clk);
        @(negedge hb_clk);
        cyc++;
        if (uart_wen || (|ack)) begin
            compared++;
            if ((|ack) !== uart_wen) begin
                mismatched++;
                $display("FAIL ack_wen_align: ack=%b wen=%b at cycle %0d", ack, uart_wen, cyc);
            end
        end
        for (int i = 0; i < NR; i++) if (ack[i] && rpos[i] < rcnt[i]) rpos[i]++;
        if (uart_wen) begin
            log_data.push_back(uart_wdata);
            log_gid.push_back(grant_id);
            log_cyc.push_back(cyc);
        end
        if (uart_auto) begin
            if (uart_wen) begin
                if (drop_delay == 0) begin
                    uart_tx_ready = 1'b0;
                    busy_cnt      = busy_len;
                end else begin
                    pend = 1'b1;
                end
            end else if (pend) begin
                pend          = 1'b0;
                uart_tx_ready = 1'b0;
                busy_cnt      = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) uart_tx_ready = 1'b1;
            end
        end
        present_all();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            step();
            k++;
        end
        compared++;
        if (log_data.size() < n) begin
            mismatched++;
            $display("FAIL wait_log_timeout: writes seen %0d, required %0d", log_data.size(), n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(busy === 1'b0 && uart_tx_ready === 1'b1 && queues_empty()) && k < 300) begin
            step();
            k++;
        end
        compared++;
        if (k >= 300) begin
            mismatched++;
            $display("FAIL wait_idle_timeout: busy=%b ready=%b", busy, uart_tx_ready);
        end
    endtask

    task automatic do_reset();
        hb_rst        = 1'b1;
        uart_tx_ready = 1'b1;
        busy_cnt      = 0;
        pend          = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rcnt[i] = 0;
            rpos[i] = 0;
        end
        present_all();
        @(negedge hb_clk);
        @(negedge hb_clk);
        hb_rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        @(negedge hb_clk);
        @(negedge hb_clk);
        compared += 5;
        if (uart_wen !== 1'b0)  begin mismatched++; $display("FAIL reset_wen: got %b want 0", uart_wen); end
        if (uart_wdata !== 8'h00) begin mismatched++; $display("FAIL reset_wdata: got %h want 00", uart_wdata); end
        if (ack !== 4'b0000)    begin mismatched++; $display("FAIL reset_ack: got %b want 0000", ack); end
        if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (grant_id !== 2'd0)  begin mismatched++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        hb_rst = 1'b0;
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d[8];
        logic [1:0] exp_g[8];
        exp_d = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h41, 8'h51, 8'h61, 8'h71};
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        uart_auto = 1'b1; drop_delay = 0; busy_len = 10;
        clear_log();
        for (int i = 0; i < NR; i++) begin
            load(i, 8'h40 + 8'(16*i), 1'b1);
            load(i, 8'h41 + 8'(16*i), 1'b1);
        end
        present_all();
        wait_log(8, 400);
        for (int k = 0; k < 8 && k < log_data.size(); k++) begin
            compared += 2;
            if (log_data[k] !== exp_d[k]) begin mismatched++; $display("FAIL fair_data[%0d]: got %h want %h", k, log_data[k], exp_d[k]); end
            if (log_gid[k] !== exp_g[k])  begin mismatched++; $display("FAIL fair_grant[%0d]: got %0d want %0d", k, log_gid[k], exp_g[k]); end
        end
        if (log_cyc.size() >= 2) begin
            compared++;
            if (log_cyc[1] - log_cyc[0] != 13) begin
                mismatched++; $display("FAIL fair_spacing: got %0d want 13", log_cyc[1] - log_cyc[0]);
            end
        end
        wait_idle();
    endtask

    task automatic test_single();
        int bc;
        clear_log();
        load(2, 8'h41, 1'b1);
        present_all();
        step();
        compared++;
        if (uart_wen !== 1'b0) begin mismatched++; $display("FAIL single_early_wen: got %b want 0", uart_wen); end
        step();
        compared += 5;
        if (uart_wen !== 1'b1)    begin mismatched++; $display("FAIL single_wen: got %b want 1", uart_wen); end
        if (uart_wdata !== 8'h41) begin mismatched++; $display("FAIL single_wdata: got %h want 41", uart_wdata); end
        if (ack !== 4'b0100)      begin mismatched++; $display("FAIL single_ack: got %b want 0100", ack); end
        if (busy !== 1'b1)        begin mismatched++; $display("FAIL single_busy: got %b want 1", busy); end
        if (grant_id !== 2'd2)    begin mismatched++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
        bc = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (busy) bc++;
            else break;
        end
        repeat (5) step();
        compared += 2;
        if (bc != 11) begin mismatched++; $display("FAIL single_busy_len: got %0d want 11", bc); end
        if (log_data.size() != 1) begin mismatched++; $display("FAIL single_write_count: got %0d want 1", log_data.size()); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        uart_auto = 1'b0;
        uart_tx_ready = 1'b0;
        clear_log();
        load(1, 8'h5A, 1'b1);
        present_all();
        repeat (50) step();
        compared += 2;
        if (log_data.size() != 0) begin mismatched++; $display("FAIL bp_no_write: got %0d writes want 0", log_data.size()); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_busy: got %b want 0", busy); end
        uart_tx_ready = 1'b1;
        step();
        compared++;
        if (uart_wen !== 1'b0) begin mismatched++; $display("FAIL bp_early_wen: got %b want 0", uart_wen); end
        step();
        compared += 3;
        if (uart_wen !== 1'b1)    begin mismatched++; $display("FAIL bp_wen: got %b want 1", uart_wen); end
        if (uart_wdata !== 8'h5A) begin mismatched++; $display("FAIL bp_wdata: got %h want 5a", uart_wdata); end
        if (ack !== 4'b0010)      begin mismatched++; $display("FAIL bp_ack: got %b want 0010", ack); end
        uart_auto = 1'b1;
        wait_idle();
    endtask

    task automatic test_guard();
        uart_auto = 1'b1; drop_delay = 1; busy_len = 10;
        clear_log();
        load(2, 8'h22, 1'b1);
        load(3, 8'h33, 1'b1);
        present_all();
        wait_log(1, 50);
        step();
        step();
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL guard_busy_held: got %b want 1", busy); end
        wait_log(2, 100);
        if (log_data.size() >= 2) begin
            compared += 3;
            if (log_data[0] !== 8'h22) begin mismatched++; $display("FAIL guard_data0: got %h want 22", log_data[0]); end
            if (log_data[1] !== 8'h33) begin mismatched++; $display("FAIL guard_data1: got %h want 33", log_data[1]); end
            if (log_cyc[1] - log_cyc[0] != 14) begin
                mismatched++; $display("FAIL guard_spacing: got %0d want 14", log_cyc[1] - log_cyc[0]);
            end
        end
        drop_delay = 0;
        wait_idle();
    endtask

    task automatic test_lock();
        logic [7:0] exp_d[4];
        logic [1:0] exp_g[4];
`ifdef UART_TX_ARB_LOCK_EN
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h20};
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h12};
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd0};
`endif
        do_reset();
        uart_auto = 1'b1; drop_delay = 0; busy_len = 3;
        load(0, 8'h10, 1'b0);
        load(0, 8'h11, 1'b0);
        load(0, 8'h12, 1'b1);
        load(1, 8'h20, 1'b1);
        present_all();
        wait_log(4, 200);
        for (int k = 0; k < 4 && k < log_data.size(); k++) begin
            compared += 2;
            if (log_data[k] !== exp_d[k]) begin mismatched++; $display("FAIL lock_data[%0d]: got %h want %h", k, log_data[k], exp_d[k]); end
            if (log_gid[k] !== exp_g[k])  begin mismatched++; $display("FAIL lock_grant[%0d]: got %0d want %0d", k, log_gid[k], exp_g[k]); end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        uart_auto = 1'b1; drop_delay = 0; busy_len = 10;
        clear_log();
        load(1, 8'h77, 1'b1);
        present_all();
        wait_log(1, 50);
        repeat (3) step();
        #2 hb_rst = 1'b1;
        #1;
        compared += 5;
        if (uart_wen !== 1'b0)    begin mismatched++; $display("FAIL midrst_wen: got %b want 0", uart_wen); end
        if (uart_wdata !== 8'h00) begin mismatched++; $display("FAIL midrst_wdata: got %h want 00", uart_wdata); end
        if (ack !== 4'b0000)      begin mismatched++; $display("FAIL midrst_ack: got %b want 0000", ack); end
        if (busy !== 1'b0)        begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (grant_id !== 2'd0)    begin mismatched++; $display("FAIL midrst_grant_id: got %0d want 0", grant_id); end
        @(negedge hb_clk);
        hb_rst = 1'b0;
        clear_log();
        load(3, 8'h3C, 1'b1);
        load(0, 8'h0C, 1'b1);
        present_all();
        wait_log(2, 100);
        if (log_data.size() >= 2) begin
            compared += 3;
            if (log_gid[0] !== 2'd0)   begin mismatched++; $display("FAIL midrst_first_grant: got %0d want 0", log_gid[0]); end
            if (log_data[0] !== 8'h0C) begin mismatched++; $display("FAIL midrst_first_data: got %h want 0c", log_data[0]); end
            if (log_gid[1] !== 2'd3)   begin mismatched++; $display("FAIL midrst_second_grant: got %0d want 3", log_gid[1]); end
        end
        wait_idle();
    endtask

    initial begin
        hb_rst        = 1'b1;
        req           = '0;
        req_last      = '0;
        req_data      = '0;
        uart_tx_ready = 1'b1;
        uart_auto     = 1'b1;
        drop_delay    = 0;
        busy_len      = 10;
        busy_cnt      = 0;
        pend          = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rcnt[i] = 0;
            rpos[i] = 0;
        end
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_guard();
        test_lock();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
